// File: rtl/encoder_4to2_hs_if.sv
// Result handshake between the priority encoder and its consumer.
interface encoder_4to2_hs_if #(
    parameter int W = 2
);
    logic [W-1:0] code;
    logic         multi;
    logic         valid;
    logic         ready;

    modport master (output code, output multi, output valid, input ready);
    modport slave  (input code, input multi, input valid, output ready);
endinterface

// File: rtl/encoder_4to2_hs.sv
// Synchronised active-low request priority encoder with a valid/ready result
// and one result per press: it re-arms only after every line reads released.
module encoder_4to2_hs #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N-1:0]     req_n,
    output logic             busy,
    encoder_4to2_hs_if.master hs
);
    if (N < 2 || (N & (N - 1)) != 0 || W != $clog2(N)) begin : g_param_check
        $error("encoder_4to2_hs: N must be a power of two >= 2 and W == log2(N)");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        RELEASE = 2'd2
    } state_t;

    logic [N-1:0] sync1_reg;
    logic [N-1:0] req_s_reg;
    logic [N-1:0] act;
    logic         any_act;
    logic [W-1:0] enc_code;
    logic         enc_multi;

    state_t       state_reg;
    logic [W-1:0] code_reg;
    logic         multi_reg;
    logic         valid_reg;
    logic         busy_reg;

    // Two-flop synchroniser; resets to "all released" so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '1;
            req_s_reg <= '1;
        end else begin
            sync1_reg <= req_n;
            req_s_reg <= sync1_reg;
        end
    end

    assign act     = ~req_s_reg;
    assign any_act = |act;

    // Ascending scan so the highest active index overwrites lower ones.
    always_comb begin
        logic seen_one;
        enc_code  = '0;
        enc_multi = 1'b0;
        seen_one  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (act[i]) begin
                enc_code = W'(i);
                if (seen_one) begin
                    enc_multi = 1'b1;
                end
                seen_one = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            code_reg  <= '0;
            multi_reg <= 1'b0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (en && any_act) begin
                        code_reg  <= enc_code;
                        multi_reg <= enc_multi;
                        valid_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                        state_reg <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (hs.ready) begin
                        valid_reg <= 1'b0;
                        state_reg <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Held requests are swallowed here until every line is released.
                    if (!any_act) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign hs.code  = code_reg;
    assign hs.multi = multi_reg;
    assign hs.valid = valid_reg;
    assign busy     = busy_reg;
endmodule

// File: tb/tb_encoder_4to2_hs.sv
// Bench for encoder_4to2_hs: directed table, handshake corner sequences and
// randomised traffic compared every cycle against a behavioural model.
module tb_encoder_4to2_hs;
    localparam int N = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [N-1:0] req_n = '1;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int accepts = 0;

    encoder_4to2_hs_if #(.W(W)) hs ();

    encoder_4to2_hs #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .req_n (req_n),
        .busy  (busy),
        .hs    (hs)
    );

    always #5 clk = ~clk;

    // Behavioural model: req_n delayed by two clocks, a pending result and an "armed" flag.
    logic [N-1:0] m_s1, m_s2;
    logic         m_pending, m_armed, m_multi;
    logic [W-1:0] m_code;

    task automatic model_reset();
        m_s1 = '1; m_s2 = '1;
        m_pending = 1'b0; m_armed = 1'b1;
        m_code = '0; m_multi = 1'b0;
    endtask

    task automatic model_edge();
        logic [N-1:0] a;
        a = ~m_s2;
        if (m_pending) begin
            if (hs.ready) begin
                m_pending = 1'b0;
                m_armed   = 1'b0;
            end
        end else if (!m_armed) begin
            if (a == '0) m_armed = 1'b1;
        end else if (en && a != '0) begin
            m_code    = W'($clog2(int'(a) + 1) - 1);
            m_multi   = ($countones(a) >= 2);
            m_pending = 1'b1;
            m_armed   = 1'b0;
        end
        m_s2 = m_s1;
        m_s1 = req_n;
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock: advance DUT and model, then compare all outputs 1 time unit later.
    task automatic step();
        bit acc;
        acc = hs.valid && hs.ready && rst_n;
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        if (acc) begin
            accepts++;
            $display("ACCEPT #%0d code=%0d multi=%0d t=%0t", accepts, hs.code, hs.multi, $time);
        end
        check("model {valid,busy,multi,code}",
              32'({hs.valid, busy, hs.multi, hs.code}),
              32'({m_pending, m_pending | ~m_armed, m_multi, m_code}));
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            step();
            if (hs.valid) ok = 1'b1;
        end
        if (!ok) check("wait_valid timeout", 32'(hs.valid), 32'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            step();
            if (!busy) ok = 1'b1;
        end
        if (!ok) check("wait_idle timeout", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [W-1:0] code;
        logic         multi;
    } vec_t;

    vec_t vecs [8];
    int   acc_before;

    initial begin
        vecs[0] = '{4'b1011, 2'd2, 1'b0};
        vecs[1] = '{4'b0110, 2'd3, 1'b1};
        vecs[2] = '{4'b1110, 2'd0, 1'b0};
        vecs[3] = '{4'b0111, 2'd3, 1'b0};
        vecs[4] = '{4'b0000, 2'd3, 1'b1};
        vecs[5] = '{4'b1100, 2'd1, 1'b1};
        vecs[6] = '{4'b1101, 2'd1, 1'b0};
        vecs[7] = '{4'b0101, 2'd3, 1'b1};

        // Reset with requests and ready asserted
        hs.ready = 1'b1; en = 1'b1; req_n = 4'b0000; rst_n = 1'b0;
        model_reset();
        repeat (3) step();
        check("reset outputs", 32'({hs.valid, busy, hs.multi, hs.code}), 32'd0);
        req_n = '1; rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("no valid after reset", 32'(hs.valid), 32'd0);
        end

        // Latency and release timing for a single request
        req_n = 4'b1011;
        step(); step();
        check("valid low after edge 2", 32'(hs.valid), 32'd0);
        step();
        check("edge3 {valid,multi,code}", 32'({hs.valid, hs.multi, hs.code}), 32'({1'b1, 1'b0, 2'd2}));
        step();
        check("valid dropped after accept", 32'(hs.valid), 32'd0);
        step(); step();
        check("busy while held", 32'(busy), 32'd1);
        req_n = '1;
        step(); step();
        check("busy before req_s clear", 32'(busy), 32'd1);
        step();
        check("busy after release", 32'(busy), 32'd0);

        // Table of single-press vectors
        acc_before = accepts;
        foreach (vecs[k]) begin
            req_n = vecs[k].req;
            wait_valid();
            check($sformatf("vec%0d {multi,code}", k), 32'({hs.multi, hs.code}),
                  32'({vecs[k].multi, vecs[k].code}));
            step();
            req_n = '1;
            wait_idle();
        end
        check("table accept count", 32'(accepts - acc_before), 32'd8);

        // Backpressure with a request change while held
        hs.ready = 1'b0; req_n = 4'b0111;
        wait_valid();
        acc_before = accepts;
        for (int i = 0; i < 10; i++) begin
            step();
            check("held {valid,code}", 32'({hs.valid, hs.code}), 32'({1'b1, 2'd3}));
            if (i == 4) req_n = 4'b1101;
        end
        hs.ready = 1'b1;
        step();
        check("valid after late accept", 32'(hs.valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("no capture while held", 32'(hs.valid), 32'd0);
        end
        req_n = '1;
        wait_idle();
        check("backpressure accepts", 32'(accepts - acc_before), 32'd1);

        // Enable gating in IDLE
        en = 1'b0; req_n = 4'b1110;
        for (int i = 0; i < 8; i++) begin
            step();
            check("en low blocks", 32'(hs.valid), 32'd0);
        end
        en = 1'b1;
        step();
        check("en raise {valid,code}", 32'({hs.valid, hs.code}), 32'({1'b1, 2'd0}));
        step();
        req_n = '1;
        wait_idle();

        // Asynchronous reset while a result is pending
        hs.ready = 1'b0; req_n = 4'b1011;
        wait_valid();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async reset valid", 32'({hs.valid, busy}), 32'd0);
        req_n = '1; hs.ready = 1'b1;
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("no stale result", 32'(hs.valid), 32'd0);
        end

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0)
                req_n = ($urandom_range(0, 2) == 0) ? N'($urandom) : '1;
            en       = ($urandom_range(0, 7) != 0);
            hs.ready = $urandom_range(0, 1) == 1;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
